// File: rtl/safe_pkg.sv
// Shared definitions for the safe keypad path.
//
// Contents:
//   DEF_DIGIT_W  - default width of one keypad digit
//   DEF_CODE_LEN - default number of digits per code
//   DIGIT_MAX    - largest legal decimal keypad digit (used when
//                  DIGIT_RANGE_CHECK_EN is defined)
//   buf_state_t  - code buffer states {IDLE, COLLECT, READY}
package safe_pkg;

  localparam int DEF_DIGIT_W  = 4;
  localparam int DEF_CODE_LEN = 4;
  localparam int DIGIT_MAX    = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } buf_state_t;

endpackage : safe_pkg

// File: rtl/entry_counter.sv
// Saturating digit counter for the code entry buffer.
//
// Ports:
//   clk         - system clock, rising edge
//   sys_reset_n - asynchronous active-low reset
//   clear       - synchronous clear to zero (wins over inc)
//   inc         - advance the count by one; ignored when full
//   count       - current count, 0..CODE_LEN
//   full        - count equals CODE_LEN
module entry_counter #(
  parameter int CODE_LEN = 4
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count,
  output logic       full
);

  logic [3:0] count_d, count_q;

  assign full  = (count_q == 4'(CODE_LEN));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear)             count_d = '0;
    else if (inc && !full) count_d = count_q + 4'd1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) count_q <= '0;
    else              count_q <= count_d;
  end

endmodule : entry_counter

// File: rtl/code_entry_buffer.sv
// Code entry buffer: collects keypad digits on store/increment strobes and
// hands a complete code to the safe controller with a ready/ack handshake.
//
// Ports:
//   clk, sys_reset_n        - clock and asynchronous active-low reset
//   digit_in                - keypad digit, sampled on store_digit_pulse
//   store_digit_pulse       - write digit_in into slot[digit_count]
//   increment_counter_pulse - advance digit_count
//   clear_entry             - level, clears everything, highest priority
//   code_ready_ack          - controller has consumed entered_code
//   entered_code            - slot 0 in the LSBs
//   digit_count             - digits accepted so far
//   code_ready              - full code valid until acknowledged
//   overflow_err            - sticky: strobe arrived while READY
//   invalid_digit           - only with DIGIT_RANGE_CHECK_EN: one-cycle pulse
//                             when a store strobe carries a digit > 9
//
// Optional feature macro: DIGIT_RANGE_CHECK_EN
module code_entry_buffer
  import safe_pkg::*;
#(
  parameter int DIGIT_W  = DEF_DIGIT_W,
  parameter int CODE_LEN = DEF_CODE_LEN
) (
  input  logic                         clk,
  input  logic                         sys_reset_n,
  input  logic [DIGIT_W-1:0]           digit_in,
  input  logic                         store_digit_pulse,
  input  logic                         increment_counter_pulse,
  input  logic                         clear_entry,
  input  logic                         code_ready_ack,
  output logic [CODE_LEN*DIGIT_W-1:0]  entered_code,
  output logic [3:0]                   digit_count,
`ifdef DIGIT_RANGE_CHECK_EN
  output logic                         invalid_digit,
`endif
  output logic                         code_ready,
  output logic                         overflow_err
);

  buf_state_t         state_d, state_q;
  logic [DIGIT_W-1:0] slot_d [CODE_LEN];
  logic [DIGIT_W-1:0] slot_q [CODE_LEN];
  logic               overflow_d, overflow_q;
  logic               invalid_d, invalid_q;
  logic               cnt_clear, cnt_inc, cnt_full;
  logic               strobe, reject, last_digit;

  entry_counter #(.CODE_LEN(CODE_LEN)) u_counter (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .count       (digit_count),
    .full        (cnt_full)
  );

  assign strobe     = store_digit_pulse | increment_counter_pulse;
  assign last_digit = (digit_count == 4'(CODE_LEN - 1));

`ifdef DIGIT_RANGE_CHECK_EN
  // An out-of-range digit kills the whole strobe, including a paired increment.
  assign reject = store_digit_pulse && (digit_in > DIGIT_W'(DIGIT_MAX));
`else
  assign reject = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    overflow_d = overflow_q;
    invalid_d  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;

    if (clear_entry) begin
      state_d    = IDLE;
      overflow_d = 1'b0;
      cnt_clear  = 1'b1;
      for (int i = 0; i < CODE_LEN; i++) slot_d[i] = '0;
    end else begin
      unique case (state_q)
        IDLE, COLLECT: begin
          if (strobe) begin
            invalid_d = reject;
            if (!reject) begin
              // Store uses the pre-increment count as the slot index.
              if (store_digit_pulse && !cnt_full) begin
                for (int i = 0; i < CODE_LEN; i++)
                  if (digit_count == 4'(i)) slot_d[i] = digit_in;
              end
              cnt_inc = increment_counter_pulse;
              state_d = (increment_counter_pulse && last_digit) ? READY : COLLECT;
            end
          end
        end
        READY: begin
          // Strobes never touch the held code; they only flag the overflow.
          if (strobe) overflow_d = 1'b1;
          if (code_ready_ack) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
            for (int i = 0; i < CODE_LEN; i++) slot_d[i] = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the slot array is reset because the code must read as zero after
  // reset; it is small enough to be plain flops rather than a RAM.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
      slot_q     <= slot_d;
    end
  end

  always_comb begin
    entered_code = '0;
    for (int i = 0; i < CODE_LEN; i++)
      entered_code[i*DIGIT_W +: DIGIT_W] = slot_q[i];
  end

  assign code_ready   = (state_q == READY);
  assign overflow_err = overflow_q;

`ifdef DIGIT_RANGE_CHECK_EN
  assign invalid_digit = invalid_q;
`else
  // Without the range check the pulse flop has no load and is trimmed away.
  logic unused_invalid;
  assign unused_invalid = invalid_q;
`endif

endmodule : code_entry_buffer

// File: tb/tb_code_entry_buffer.sv
// Self-checking bench for code_entry_buffer: directed scenarios followed by
// random strobes, all compared against a slot-array reference model.
module tb_code_entry_buffer;

  localparam int DW = 4;
  localparam int CL = 4;

  logic            clk = 1'b0;
  logic            sys_reset_n;
  logic [DW-1:0]   digit_in;
  logic            store_digit_pulse, increment_counter_pulse;
  logic            clear_entry, code_ready_ack;
  logic [CL*DW-1:0] entered_code;
  logic [3:0]      digit_count;
  logic            code_ready, overflow_err;
`ifdef DIGIT_RANGE_CHECK_EN
  logic            invalid_digit;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model
  int m_slot [CL];
  int m_cnt;
  bit m_ready, m_ovf, m_inv;

  code_entry_buffer #(.DIGIT_W(DW), .CODE_LEN(CL)) dut (
    .clk                     (clk),
    .sys_reset_n             (sys_reset_n),
    .digit_in                (digit_in),
    .store_digit_pulse       (store_digit_pulse),
    .increment_counter_pulse (increment_counter_pulse),
    .clear_entry             (clear_entry),
    .code_ready_ack          (code_ready_ack),
    .entered_code            (entered_code),
    .digit_count             (digit_count),
`ifdef DIGIT_RANGE_CHECK_EN
    .invalid_digit           (invalid_digit),
`endif
    .code_ready              (code_ready),
    .overflow_err            (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CL; i++) m_slot[i] = 0;
    m_cnt = 0; m_ready = 0; m_ovf = 0; m_inv = 0;
  endtask

  function automatic logic [CL*DW-1:0] model_code();
    logic [CL*DW-1:0] c = '0;
    for (int i = 0; i < CL; i++) c = c | (CL*DW)'(m_slot[i] << (DW*i));
    return c;
  endfunction

  // Apply one cycle of the buffer rules to the model.
  task automatic model_step(input bit st, input bit inc, input int d, input bit clr, input bit ack);
    bit rej;
    m_inv = 0;
    if (clr) begin
      model_reset();
    end else if (m_ready) begin
      if (st || inc) m_ovf = 1;
      if (ack) begin
        for (int i = 0; i < CL; i++) m_slot[i] = 0;
        m_cnt = 0; m_ready = 0;
      end
    end else begin
      rej = 0;
`ifdef DIGIT_RANGE_CHECK_EN
      rej = st && (d > 9);
      m_inv = rej;
`endif
      if (!rej) begin
        if (st) m_slot[m_cnt] = d;
        if (inc) m_cnt++;
        if (m_cnt == CL) m_ready = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 64'(digit_count),  64'(m_cnt));
    check({tag, ".code"},  64'(entered_code), 64'(model_code()));
    check({tag, ".ready"}, 64'(code_ready),   64'(m_ready));
    check({tag, ".ovf"},   64'(overflow_err), 64'(m_ovf));
`ifdef DIGIT_RANGE_CHECK_EN
    check({tag, ".inv"},   64'(invalid_digit), 64'(m_inv));
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic step(input string tag, input bit st, input bit inc, input int d,
                      input bit clr = 0, input bit ack = 0);
    @(negedge clk);
    store_digit_pulse       = st;
    increment_counter_pulse = inc;
    digit_in                = DW'(d);
    clear_entry             = clr;
    code_ready_ack          = ack;
    @(posedge clk);
    #1;
    model_step(st, inc, d, clr, ack);
    store_digit_pulse = 0; increment_counter_pulse = 0;
    clear_entry = 0; code_ready_ack = 0;
    check_all(tag);
  endtask

  initial begin
    sys_reset_n = 0;
    digit_in = '0; store_digit_pulse = 0; increment_counter_pulse = 0;
    clear_entry = 0; code_ready_ack = 0;
    model_reset();
    #22 sys_reset_n = 1;

    // Reset state
    check("rst.code",  64'(entered_code), 64'h0);
    check("rst.count", 64'(digit_count),  64'h0);
    check("rst.ready", 64'(code_ready),   64'h0);
    check("rst.ovf",   64'(overflow_err), 64'h0);

    // Four paired strobes 1..4
    for (int k = 1; k <= 4; k++) begin
      step($sformatf("pair%0d", k), 1, 1, k);
      check($sformatf("pair%0d.cnt_const", k), 64'(digit_count), 64'(k));
    end
    check("full.code_const",  64'(entered_code), 64'h4321);
    check("full.ready_const", 64'(code_ready),   64'h1);

    // Strobe while READY, then acknowledge
    step("ready_strobe", 1, 1, 7);
    check("ready_strobe.code_const", 64'(entered_code), 64'h4321);
    check("ready_strobe.ovf_const",  64'(overflow_err), 64'h1);
    step("ack", 0, 0, 0, 0, 1);
    check("ack.code_const", 64'(entered_code), 64'h0);
    check("ack.ovf_const",  64'(overflow_err), 64'h1);
    step("ack_idle", 0, 0, 0, 0, 1);

    // Store-only overwrite, then increment-only skip
    step("store_only", 1, 0, 5);
    step("pair6", 1, 1, 6);
    check("pair6.code_const", 64'(entered_code), 64'h0006);
    step("inc_only", 0, 1, 0);
    check("inc_only.cnt_const", 64'(digit_count), 64'h2);

    // Clear coincident with a strobe drops the strobe
    step("clear_strobe", 1, 1, 8, 1, 0);
    check("clear.code_const", 64'(entered_code), 64'h0);
    check("clear.ovf_const",  64'(overflow_err), 64'h0);

    // Asynchronous reset mid-collection
    for (int k = 0; k < 3; k++) step("pre_rst", 1, 1, k + 2);
    #1 sys_reset_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    #4 sys_reset_n = 1;
    for (int k = 0; k < 4; k++) step("post_rst", 1, 1, 9 - k);
    check("post_rst.code_const", 64'(entered_code), 64'h6789);
    step("post_rst.ack", 0, 0, 0, 0, 1);

`ifdef DIGIT_RANGE_CHECK_EN
    step("bad_digit", 1, 1, 10);
    check("bad_digit.inv_const", 64'(invalid_digit), 64'h1);
    step("good9", 1, 1, 9);
    check("good9.inv_const",  64'(invalid_digit), 64'h0);
    check("good9.code_const", 64'(entered_code),  64'h0009);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      bit st, inc, clr, ack;
      r   = int'($urandom_range(0, 99));
      st  = (r < 70) && ($urandom_range(0, 3) != 0);
      inc = (r < 70) && ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      ack = ($urandom_range(0, 5) == 0);
      step("rand", st, inc, int'($urandom_range(0, 15)), clr, ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule : tb_code_entry_buffer

// File: doc/code_entry_buffer.md
# code_entry_buffer

Consumer side of the keypad entry path: receives the one-cycle `store_digit_pulse` / `increment_counter_pulse` strobes produced by the entry handler, captures the current keypad digit into a code buffer, and counts digits entered. When a full code has been collected it presents the code with a ready/acknowledge handshake to the safe controller FSM, which compares it and then releases the buffer.

## Interface
- `DIGIT_W`, 4: width of one keypad digit.
- `CODE_LEN`, 4: digits per code; legal range 1–15.
- `clk` input 1: system clock, rising edge.
- `sys_reset_n` input 1: asynchronous, active-low reset.
- `digit_in` input DIGIT_W: current keypad digit; sampled only on a store strobe.
- `store_digit_pulse` input 1: one-cycle strobe to write `digit_in` into the slot at the current count.
- `increment_counter_pulse` input 1: one-cycle strobe to advance the digit count.
- `clear_entry` input 1: level; synchronously clears the buffer and count.
- `code_ready_ack` input 1: controller has consumed `entered_code`.
- `entered_code` output CODE_LEN*DIGIT_W: slot 0 (first digit) occupies the LSBs.
- `digit_count` output 4: digits accepted so far, 0..CODE_LEN.
- `code_ready` output 1: full code is valid, held until acknowledged.
- `overflow_err` output 1: sticky; a strobe arrived while the buffer was READY.

## Operation
- Reset values: every output is 0, every slot is 0, state is IDLE.
- States:
  - IDLE (count 0): a strobe moves the FSM to COLLECT.
  - COLLECT: accepts strobes; moves to READY when the count reaches CODE_LEN.
  - READY: `code_ready`=1; no strobe modifies the slots or the count.
- Store strobe: slot[`digit_count`] ← `digit_in`, using the pre-increment count.
- Increment strobe: `digit_count` ← `digit_count`+1.
- Both strobes in the same cycle (the normal case): the digit is written to the old index, then the count advances.
- Store strobe alone: overwrites the current slot; the count is unchanged.
- Increment strobe alone: the count advances and the skipped slot keeps its old value (0 after a clear).
- Reaching the final count: the transition to READY happens on the same edge that makes the count equal CODE_LEN.
- Strobe in READY: the strobe is ignored and `overflow_err` is set. It clears only on reset or `clear_entry`.
- Handshake: `code_ready_ack` while READY clears all slots, the count and `code_ready`, and the FSM returns to IDLE. `code_ready_ack` outside READY has no effect.
- `clear_entry` has priority over strobes and ack in every state. It clears the slots, the count, `code_ready` and `overflow_err`, and forces IDLE.
- The count never exceeds CODE_LEN, so no wrap-around is possible.

## Timing
- Everything is registered; no combinational path from input to output.
- `digit_count` and the slot update are visible 1 cycle after the strobe edge.
- `code_ready` rises 1 cycle after the final strobe, i.e. on the same edge as the count update.
- Release: `code_ready` falls on the edge that samples `code_ready_ack`=1. A strobe arriving in that same cycle is treated as a READY strobe: it is ignored and sets `overflow_err`.
- `sys_reset_n` low clears all state immediately, including mid-collection. The first strobe after deassertion is honoured if it is sampled on a clean edge.

## Configuration
- `DIGIT_RANGE_CHECK_EN` defined:
  - A store strobe with `digit_in` > 9 is rejected: no write, and no increment even if the increment strobe coincides.
  - The extra output `invalid_digit` (1 bit, reset 0) pulses high for 1 cycle.
- Undefined: every `digit_in` value is accepted and the `invalid_digit` port is absent.

## Structure
- Shared package `safe_pkg` holds:
  - `DIGIT_W` and `CODE_LEN` defaults;
  - the `buf_state_t` enum {IDLE, COLLECT, READY};
  - the `DIGIT_MAX` = 9 constant.
- Sub-module `entry_counter`: saturating up-counter with synchronous clear, increment enable and a `full` flag at CODE_LEN. The top level holds the FSM and the slot registers.

## Test plan
- Reset then 4 paired strobes with digits 1, 2, 3, 4 → `digit_count` steps 1..4, `code_ready`=1 one cycle after the 4th strobe, `entered_code`=16'h4321.
- While READY, issue 1 strobe with digit 7 → `entered_code` unchanged at 16'h4321, `overflow_err`=1. Then assert `code_ready_ack` → all outputs return to 0 except `overflow_err`, which stays 1.
- Store-only with 5, then a paired strobe with 6 → slot0=6, count 1. Increment-only → count 2, slot1=0.
- 2 digits entered, then `clear_entry` coincident with a strobe → count 0, slots 0, state IDLE, and the strobe is dropped.
- Drive `sys_reset_n` low for 5 ns between clock edges mid-collection (count 3) → all outputs 0 immediately. Then 4 new digits → normal READY.
- With `DIGIT_RANGE_CHECK_EN`: paired strobe with digit 4'hA → `invalid_digit` pulses for 1 cycle, count stays 0. The following digit 9 is stored in slot0.
